// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and header count decode for the fifo arbiters
package fifo_arb_pkg;

  localparam int CWIDTH = 3;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  function automatic logic [3:0] count_len(input logic [CWIDTH-1:0] field);
    case (field)
      3'd1:    count_len = 4'd1;
      3'd2:    count_len = 4'd2;
      3'd3:    count_len = 4'd4;
      3'd4:    count_len = 4'd8;
      default: count_len = 4'd0;
    endcase
  endfunction

  function automatic int lsb_index(input logic [31:0] mask);
    lsb_index = 0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i]) lsb_index = i;
    end
  endfunction

endpackage

// File: rtl/fifo_arb_tx_if.sv
// rtl/fifo_arb_tx_if.sv - client write ports and output FIFO port of the tx arbiter
interface fifo_arb_tx_if #(parameter int DWIDTH = 8);

  logic              c1_wren;
  logic              c1_wrfull;
  logic [DWIDTH-1:0] c1_wrdata;
  logic              c2_wren;
  logic              c2_wrfull;
  logic [DWIDTH-1:0] c2_wrdata;
  logic              fifo_wren;
  logic              fifo_wrfull;
  logic [DWIDTH-1:0] fifo_wrdata;
  logic              busy;

  modport slave (
    input  c1_wren, c1_wrdata, c2_wren, c2_wrdata, fifo_wrfull,
    output c1_wrfull, c2_wrfull, fifo_wren, fifo_wrdata, busy
  );

  modport master (
    output c1_wren, c1_wrdata, c2_wren, c2_wrdata, fifo_wrfull,
    input  c1_wrfull, c2_wrfull, fifo_wren, fifo_wrdata, busy
  );

endinterface

// File: rtl/fifo.sv
// rtl/fifo.sv - standard synchronous FIFO, registered read data one cycle after rd_en
module fifo #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic              empty
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [AWIDTH:0]   wptr;
  logic [AWIDTH:0]   wptr_vis;
  logic [AWIDTH:0]   rptr;

  // The read side sees the write pointer through one register stage.
  assign full  = (wptr[AWIDTH] != rptr[AWIDTH]) && (wptr[AWIDTH-1:0] == rptr[AWIDTH-1:0]);
  assign empty = (wptr_vis == rptr);

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wptr[AWIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr     <= '0;
      wptr_vis <= '0;
      rptr     <= '0;
      rd_data  <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + (AWIDTH+1)'(1);
      wptr_vis <= wptr;
      if (rd_en && !empty) begin
        rd_data <= mem[rptr[AWIDTH-1:0]];
        rptr    <= rptr + (AWIDTH+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_arb_skid.sv
// rtl/fifo_arb_skid.sv - 2-entry output skid buffer in front of the shared output FIFO
module fifo_arb_skid #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              out_full,
  output logic              wren,
  output logic [DWIDTH-1:0] data,
  output logic [1:0]        cnt
);

  logic [DWIDTH-1:0] ent0;
  logic [DWIDTH-1:0] ent1;
  logic              pop;

  assign pop  = (cnt != 2'd0) && !out_full;
  assign wren = pop;
  assign data = ent0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_arb_tx.sv
// rtl/fifo_arb_tx.sv - merges whole packets from two clients into one output FIFO, stamping the route bit
module fifo_arb_tx
  import fifo_arb_pkg::*;
#(
  parameter int                DWIDTH  = 8,
  parameter int                AWIDTH  = 3,
  parameter logic [DWIDTH-1:0] SELMASK = 8'h80,
  parameter logic [DWIDTH-1:0] CNTMASK = 8'h70,
  parameter bit                REWRITE = 1'b1
) (
  input logic          CLK,
  input logic          RESETn,
  fifo_arb_tx_if.slave bus
);

  localparam int CSHIFT = lsb_index(32'(CNTMASK));

  state_t            state, state_n;
  logic              last_c2, last_c2_n;
  logic [3:0]        rem, rem_n;
  logic              rd_q;
  logic              rd_c1, rd_c2;
  logic              c1_empty, c2_empty;
  logic [DWIDTH-1:0] c1_rd_data, c2_rd_data;
  logic [DWIDTH-1:0] hdr_raw, hdr_shift, stamped, push_data;
  logic [CWIDTH-1:0] field;
  logic [3:0]        hdr_len;
  logic [1:0]        skid_cnt;
  logic [2:0]        load;
  logic              credit;
  logic              grant_empty;

  fifo #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_c1_fifo (
    .clk(CLK), .resetn(RESETn),
    .wr_en(bus.c1_wren), .wr_data(bus.c1_wrdata), .full(bus.c1_wrfull),
    .rd_en(rd_c1), .rd_data(c1_rd_data), .empty(c1_empty)
  );

  fifo #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_c2_fifo (
    .clk(CLK), .resetn(RESETn),
    .wr_en(bus.c2_wren), .wr_data(bus.c2_wrdata), .full(bus.c2_wrfull),
    .rd_en(rd_c2), .rd_data(c2_rd_data), .empty(c2_empty)
  );

  fifo_arb_skid #(.DWIDTH(DWIDTH)) u_skid (
    .clk(CLK), .resetn(RESETn),
    .push(rd_q), .push_data(push_data),
    .out_full(bus.fifo_wrfull), .wren(bus.fifo_wren), .data(bus.fifo_wrdata),
    .cnt(skid_cnt)
  );

  // Data returning this cycle always belongs to the current grant; length uses the unstamped header.
  assign hdr_raw     = last_c2 ? c2_rd_data : c1_rd_data;
  assign hdr_shift   = hdr_raw >> CSHIFT;
  assign field       = hdr_shift[CWIDTH-1:0];
  assign hdr_len     = count_len(field);
  assign grant_empty = last_c2 ? c2_empty : c1_empty;

  // Occupancy the skid will have after this edge must leave room for a read issued now.
  assign load   = {1'b0, skid_cnt} + {2'b0, rd_q} - {2'b0, bus.fifo_wren};
  assign credit = (load < 3'd2);

  assign bus.busy = (state != IDLE) || (skid_cnt != 2'd0) || rd_q;

  always_comb begin
    stamped = hdr_raw;
    if (REWRITE) stamped = last_c2 ? (hdr_raw & ~SELMASK) : (hdr_raw | SELMASK);
    push_data = (state == HDR) ? stamped : hdr_raw;
  end

  always_comb begin
    state_n   = state;
    last_c2_n = last_c2;
    rem_n     = rem;
    rd_c1     = 1'b0;
    rd_c2     = 1'b0;
    case (state)
      IDLE: begin
        if (credit) begin
          if (!c1_empty && (c2_empty || last_c2)) begin
            rd_c1     = 1'b1;
            last_c2_n = 1'b0;
            state_n   = HDR;
          end else if (!c2_empty) begin
            rd_c2     = 1'b1;
            last_c2_n = 1'b1;
            state_n   = HDR;
          end
        end
      end
      HDR: begin
        rem_n   = hdr_len;
        state_n = (hdr_len == 4'd0) ? IDLE : BODY;
      end
      BODY: begin
        if (credit && !grant_empty) begin
          rd_c1 = !last_c2;
          rd_c2 = last_c2;
          rem_n = rem - 4'd1;
          if (rem == 4'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state   <= IDLE;
      last_c2 <= 1'b1;
      rem     <= 4'd0;
      rd_q    <= 1'b0;
    end else begin
      state   <= state_n;
      last_c2 <= last_c2_n;
      rem     <= rem_n;
      rd_q    <= rd_c1 | rd_c2;
    end
  end

endmodule

// File: tb/tb_fifo_arb_tx.sv
// tb/tb_fifo_arb_tx.sv - directed table-driven bench for fifo_arb_tx
module tb_fifo_arb_tx;

  typedef struct packed {
    logic [1:0]      client;
    logic [3:0]      nin;
    logic [0:8][7:0] din;
    logic [3:0]      nout;
    logic [0:8][7:0] dout;
  } vec_t;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  logic [7:0] out_q [$];
  vec_t vecs [5];

  fifo_arb_tx_if #(.DWIDTH(8)) bus ();

  fifo_arb_tx dut (
    .CLK(clk),
    .RESETn(resetn),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (resetn && bus.fifo_wren) out_q.push_back(bus.fifo_wrdata);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_pkt(input logic [1:0] c, input int n, input logic [0:8][7:0] d);
    for (int i = 0; i < n; i++) begin
      if (c == 2'd1) begin bus.c1_wren = 1'b1; bus.c1_wrdata = d[i]; end
      else           begin bus.c2_wren = 1'b1; bus.c2_wrdata = d[i]; end
      tick();
    end
    bus.c1_wren = 1'b0;
    bus.c2_wren = 1'b0;
  endtask

  task automatic wait_count(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (out_q.size() < n) chk({name, " timeout"}, out_q.size(), n);
  endtask

  task automatic expect_out(input string name, input int n, input logic [0:8][7:0] exp);
    wait_count(name, n, 60);
    repeat (4) tick();
    chk({name, " count"}, out_q.size(), n);
    for (int j = 0; j < n; j++) begin
      if (j < out_q.size()) chk($sformatf("%s byte%0d", name, j), out_q[j], exp[j]);
    end
    chk({name, " busy idle"}, bus.busy, 1'b0);
    out_q.delete();
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    vecs[0] = '{client: 2'd1, nin: 4'd2, din: {8'h13, 8'hAA, 56'h0},
                nout: 4'd2, dout: {8'h93, 8'hAA, 56'h0}};
    vecs[1] = '{client: 2'd2, nin: 4'd5, din: {8'hB0, 8'h11, 8'h22, 8'h33, 8'h44, 32'h0},
                nout: 4'd5, dout: {8'h30, 8'h11, 8'h22, 8'h33, 8'h44, 32'h0}};
    vecs[2] = '{client: 2'd2, nin: 4'd3, din: {8'hA0, 8'hC1, 8'hC2, 48'h0},
                nout: 4'd3, dout: {8'h20, 8'hC1, 8'hC2, 48'h0}};
    vecs[3] = '{client: 2'd1, nin: 4'd2, din: {8'h50, 8'h01, 56'h0},
                nout: 4'd2, dout: {8'hD0, 8'h81, 56'h0}};
    vecs[4] = '{client: 2'd1, nin: 4'd1, din: {8'h00, 64'h0},
                nout: 4'd1, dout: {8'h80, 64'h0}};

    bus.c1_wren = 1'b0; bus.c1_wrdata = 8'h00;
    bus.c2_wren = 1'b0; bus.c2_wrdata = 8'h00;
    bus.fifo_wrfull = 1'b0;
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    chk("reset fifo_wren", bus.fifo_wren, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset c1_wrfull", bus.c1_wrfull, 1'b0);
    chk("reset c2_wrfull", bus.c2_wrfull, 1'b0);
    chk("reset fifo_wrdata", bus.fifo_wrdata, 8'h00);

    // Simultaneous load straight after reset: client 1 wins the first tie.
    for (int i = 0; i < 2; i++) begin
      bus.c1_wren = 1'b1; bus.c1_wrdata = (i == 0) ? 8'h11 : 8'hA1;
      bus.c2_wren = 1'b1; bus.c2_wrdata = (i == 0) ? 8'h95 : 8'hB1;
      tick();
    end
    bus.c1_wren = 1'b0; bus.c2_wren = 1'b0;
    expect_out("rr1", 4, {8'h91, 8'hA1, 8'h15, 8'hB1, 40'h0});

    for (int v = 0; v < 5; v++) begin
      drive_pkt(vecs[v].client, int'(vecs[v].nin), vecs[v].din);
      expect_out($sformatf("vec%0d", v), int'(vecs[v].nout), vecs[v].dout);
    end

    // Client 1 was served last, so client 2 wins this tie.
    for (int i = 0; i < 2; i++) begin
      bus.c1_wren = 1'b1; bus.c1_wrdata = (i == 0) ? 8'h12 : 8'hC3;
      bus.c2_wren = 1'b1; bus.c2_wrdata = (i == 0) ? 8'h9A : 8'hD4;
      tick();
    end
    bus.c1_wren = 1'b0; bus.c2_wren = 1'b0;
    expect_out("rr2", 4, {8'h1A, 8'hD4, 8'h92, 8'hC3, 40'h0});

    // Output FIFO full for 5 cycles in the middle of an 8-byte body.
    fork
      drive_pkt(2'd1, 9, {8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
      begin
        wait_count("stall pre", 3, 40);
        bus.fifo_wrfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("stall wren%0d", k), bus.fifo_wren, 1'b0);
          tick();
        end
        bus.fifo_wrfull = 1'b0;
      end
    join
    expect_out("stall", 9, {8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});

    // Freeze the output, fill client 2, then reset in the middle of a body.
    bus.fifo_wrfull = 1'b1;
    drive_pkt(2'd1, 9, {8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
    drive_pkt(2'd2, 8, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    chk("pre-reset c2_wrfull", bus.c2_wrfull, 1'b1);
    chk("pre-reset busy", bus.busy, 1'b1);
    resetn = 1'b0;
    bus.fifo_wrfull = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("mid reset fifo_wren", bus.fifo_wren, 1'b0);
    chk("mid reset busy", bus.busy, 1'b0);
    chk("mid reset c1_wrfull", bus.c1_wrfull, 1'b0);
    chk("mid reset c2_wrfull", bus.c2_wrfull, 1'b0);
    tick();
    out_q.delete();

    // Post-reset packet also measures write-to-output latency.
    lat = -1;
    bus.c2_wren = 1'b1;
    bus.c2_wrdata = 8'h93;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.fifo_wren && lat < 0) lat = k;
      tick();
      if (k == 0) bus.c2_wrdata = 8'h77;
      else if (k == 1) bus.c2_wren = 1'b0;
    end
    chk("latency", lat, 4);
    expect_out("post reset", 2, {8'h13, 8'h77, 56'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_arb_tx.md
Name: fifo_arb_tx

Overview:
Transmit-side counterpart of the rx arbiter. It merges packets from two client write ports into one shared output FIFO. Each client writes into its own internal FIFO; the block forwards whole packets (header plus body) atomically, with no interleaving of clients inside a packet. It stamps the SELMASK route bit into each header so the far-end rx arbiter steers client-1 traffic to its c1 and client-2 traffic to its c2.

Parameters:
SELMASK, 8'h80, header bits forced to 1 on client-1 headers and forced to 0 on client-2 headers.
CNTMASK, 8'h70, contiguous 3-bit count field in the header; must not overlap SELMASK.
DWIDTH, 8, data width.
AWIDTH, 3, address width of each internal client FIFO (depth 2**AWIDTH).
REWRITE, 1, 1 = apply SELMASK stamping; 0 = pass headers unchanged.

Ports:
CLK  in  1  clock
RESETn  in  1  synchronous active-low reset
c1_wren  in  1  client 1 write strobe
c1_wrfull  out  1  client 1 internal FIFO full
c1_wrdata  in  DWIDTH  client 1 write data
c2_wren  in  1  client 2 write strobe
c2_wrfull  out  1  client 2 internal FIFO full
c2_wrdata  in  DWIDTH  client 2 write data
fifo_wren  out  1  output FIFO write strobe
fifo_wrfull  in  1  output FIFO full
fifo_wrdata  out  DWIDTH  output FIFO write data
busy  out  1  packet in progress, or skid buffer non-empty

Behaviour:
- Single clock domain: CLK. Reset is synchronous and active-low (RESETn). Reset clears FSM, counters, skid buffer and both internal FIFOs. Reset values: fifo_wren=0, busy=0, c1_wrfull=0, c2_wrfull=0, fifo_wrdata=0.
- Internal FIFOs are instances of the standard fifo. Read data is valid the cycle after rd_en.
- A write while cN_wrfull=1 is dropped. Clients must honour cN_wrfull.
- Count decode:
  - field = (hdr >> CSHIFT) & 7, where CSHIFT = index of the lowest set bit of CNTMASK.
  - Body length by field value: 0->0, 1->1, 2->2, 3->4, 4->8, 5..7 reserved ->0.
  - Header 8'h00 is a 1-byte packet.
  - Length decode uses the header before stamping.
- FSM:
  - IDLE: pick a non-empty client FIFO and issue a header rd_en -> HDR. Both empty: stay.
  - HDR: header arrives. Stamp it, push to skid, load rem = body length. rem=0 -> IDLE, else -> BODY. No read is issued in HDR (one-cycle bubble per packet).
  - BODY: issue rd_en to the granted FIFO each cycle while it is non-empty and skid space allows. Decrement rem on issue. The last issue -> IDLE.
  - An underflowing granted FIFO stalls BODY. The other client is never served mid-packet.
- Arbitration (IDLE only): round-robin. On a tie, the client not served last wins. last_grant resets to client 2, so client 1 wins the first tie.
- Stamping (REWRITE=1), header bytes only:
  - Client 1: hdr | SELMASK.
  - Client 2: hdr & ~SELMASK.
  - Body bytes pass unchanged.
- Output skid buffer (2 entries, FIFO order):
  - fifo_wren = skid_nonempty & ~fifo_wrfull. fifo_wrdata = skid head.
  - A read may be issued only if (skid occupancy + reads in flight - drain this cycle) < 2.
  - Throughput is 1 byte/cycle while fifo_wrfull=0. No byte is lost or duplicated when fifo_wrfull toggles.
- Minimum latency: c1_wren at cycle t -> header on fifo_wren at t+4. Successive body bytes follow on consecutive cycles.
- Simultaneous client writes during a packet are accepted into the internal FIFOs. A reset mid-packet drops all buffered data.

Decomposition:
- Package fifo_arb_pkg holds:
  - the count-decode function (field -> length), shared with fifo_arb_rx;
  - the CWIDTH=3 constant;
  - the FSM state enum {IDLE, HDR, BODY}.
- Sub-modules: reuse the existing fifo twice. Optional sub-module fifo_arb_skid (2-entry skid buffer).

Test Plan:
1. Client 1 writes 8'h13, 8'hAA (field 1, 1 body byte) -> output 8'h93, 8'hAA on consecutive fifo_wren. busy returns to 0.
2. Client 2 writes 8'hB0, 11, 22, 33, 44 (field 3, 4 body bytes) -> output 8'h30, 11, 22, 33, 44.
3. Both clients load 2-byte packets in the same cycle -> c1 packet complete, then c2 packet. Repeat -> c2 first, then c1 (round-robin).
4. 8-byte-body c1 packet with fifo_wrfull high for 5 cycles mid-body -> all 9 bytes out in order, none duplicated, fifo_wren=0 while full.
5. Header 8'h50 (reserved field 5) from client 1, followed by 8'h01 -> treated as two 1-byte packets: 8'hD0, then 8'h81.
6. RESETn low for 1 cycle mid-BODY -> fifo_wren=0 next cycle, busy=0, both cN_wrfull=0. The next new packet is output correctly.
